// File: rtl/wic_pkg.sv
// Shared constants for the VIC interrupt arbiter: default sizing, vector width
// and the arbiter FSM encoding.
package wic_pkg;
  localparam int DEF_INT_NUM    = 32;
  localparam int DEF_PRIO_W     = 2;
  localparam int DEF_NEST_DEPTH = 4;
  localparam int VEC_W          = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_CLR  = 2'd2;
endpackage

// File: rtl/vic_prio_sel.sv
// Combinational winner select: highest priority among candidates, lowest index on ties.
module vic_prio_sel import wic_pkg::*; #(
  parameter int INT_NUM = DEF_INT_NUM,
  parameter int PRIO_W  = DEF_PRIO_W
) (
  input  logic [INT_NUM-1:0]        cand,
  input  logic [INT_NUM*PRIO_W-1:0] int_prio,
  output logic                      winner_vld,
  output logic [VEC_W-1:0]          winner_vec,
  output logic [PRIO_W-1:0]         winner_prio
);
  logic [INT_NUM-1:0][PRIO_W-1:0] prio_a;

  assign prio_a = int_prio;

  // Ascending scan replacing only on strictly greater priority keeps the lowest index on ties.
  always_comb begin
    winner_vld  = 1'b0;
    winner_vec  = '0;
    winner_prio = '0;
    for (int i = 0; i < INT_NUM; i++) begin
      if (cand[i] && (!winner_vld || (prio_a[i] > winner_prio))) begin
        winner_vld  = 1'b1;
        winner_vec  = VEC_W'(i);
        winner_prio = prio_a[i];
      end
    end
  end
endmodule

// File: rtl/vic_int_arb.sv
// Interrupt arbiter: presents the best qualifying source to the CPU, tracks nested
// handler priorities on a stack and pulses the WIC pending-clear on acknowledge.
module vic_int_arb import wic_pkg::*; #(
  parameter int INT_NUM    = DEF_INT_NUM,
  parameter int PRIO_W     = DEF_PRIO_W,
  parameter int NEST_DEPTH = DEF_NEST_DEPTH
) (
  input  logic                      wic_clk,
  input  logic                      pad_cpu_rst_b,
  input  logic [INT_NUM-1:0]        int_pending,
  input  logic [INT_NUM-1:0]        int_enable,
  input  logic [INT_NUM*PRIO_W-1:0] int_prio,
  input  logic                      arb_en,
  input  logic                      cpu_int_ack,
  input  logic                      cpu_int_exit,
  output logic                      arb_int_req,
  output logic [VEC_W-1:0]          arb_int_vec,
  output logic [PRIO_W-1:0]         arb_int_prio,
  output logic [INT_NUM-1:0]        arb_pending_clr,
  output logic [2:0]                arb_nest_lvl,
  output logic                      arb_exit_err
);
  logic [1:0]                        state_q, state_d;
  logic [VEC_W-1:0]                  vec_q, vec_d;
  logic [PRIO_W-1:0]                 prio_q, prio_d;
  logic [2:0]                        lvl_q, lvl_d;
  logic                              err_q, err_d;
  logic [NEST_DEPTH-1:0][PRIO_W-1:0] stk_q, stk_d;

  logic              w_vld;
  logic [VEC_W-1:0]  w_vec;
  logic [PRIO_W-1:0] w_prio;
  logic [PRIO_W-1:0] top;
  logic              qual, push, pop;

  vic_prio_sel #(.INT_NUM(INT_NUM), .PRIO_W(PRIO_W)) u_sel (
    .cand        (int_pending & int_enable),
    .int_prio    (int_prio),
    .winner_vld  (w_vld),
    .winner_vec  (w_vec),
    .winner_prio (w_prio)
  );

  always_comb begin
    top = '0;
    for (int i = 0; i < NEST_DEPTH; i++)
      if (i == int'(lvl_q) - 1) top = stk_q[i];
  end

  assign qual = arb_en && w_vld && (int'(lvl_q) < NEST_DEPTH) &&
                ((lvl_q == 3'd0) || (w_prio > top));
  assign push = (state_q == ST_REQ) && cpu_int_ack;
  assign pop  = cpu_int_exit && (lvl_q != 3'd0);

  // Simultaneous pop+push overwrites the current top in place.
  always_comb begin
    stk_d = stk_q;
    lvl_d = lvl_q;
    err_d = err_q | (cpu_int_exit && (lvl_q == 3'd0));
    for (int i = 0; i < NEST_DEPTH; i++) begin
      if (push && pop && (i == int'(lvl_q) - 1)) stk_d[i] = prio_q;
      else if (push && !pop && (i == int'(lvl_q))) stk_d[i] = prio_q;
    end
    if (push && !pop)      lvl_d = lvl_q + 3'd1;
    else if (pop && !push) lvl_d = lvl_q - 3'd1;
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    prio_d  = prio_q;
    case (state_q)
      ST_IDLE: if (qual) begin
        vec_d   = w_vec;
        prio_d  = w_prio;
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (cpu_int_ack) state_d = ST_CLR;
        else if (qual) begin
          vec_d  = w_vec;
          prio_d = w_prio;
        end else state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wic_clk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      prio_q  <= '0;
      lvl_q   <= '0;
      err_q   <= 1'b0;
      stk_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      prio_q  <= prio_d;
      lvl_q   <= lvl_d;
      err_q   <= err_d;
      stk_q   <= stk_d;
    end
  end

  always_comb begin
    arb_pending_clr = '0;
    if (state_q == ST_CLR) arb_pending_clr[vec_q] = 1'b1;
  end

  assign arb_int_req  = (state_q == ST_REQ);
  assign arb_int_vec  = vec_q;
  assign arb_int_prio = prio_q;
  assign arb_nest_lvl = lvl_q;
  assign arb_exit_err = err_q;
endmodule

// File: tb/tb_vic_int_arb.sv
// Directed bench for vic_int_arb: expected per-cycle outputs are queued as stimulus
// is applied and compared once the DUT has clocked.
module tb_vic_int_arb;
  logic        wic_clk = 1'b0;
  logic        pad_cpu_rst_b;
  logic [31:0] int_pending, int_enable;
  logic [63:0] int_prio;
  logic        arb_en, cpu_int_ack, cpu_int_exit;
  logic        arb_int_req;
  logic [4:0]  arb_int_vec;
  logic [1:0]  arb_int_prio;
  logic [31:0] arb_pending_clr;
  logic [2:0]  arb_nest_lvl;
  logic        arb_exit_err;

  typedef struct {
    string       tag;
    logic        req;
    logic [4:0]  vec;
    logic [1:0]  prio;
    bit          cv;
    logic [31:0] clr;
    logic [2:0]  lvl;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  logic err_exp = 1'b0;

  vic_int_arb u_dut (
    .wic_clk(wic_clk), .pad_cpu_rst_b(pad_cpu_rst_b),
    .int_pending(int_pending), .int_enable(int_enable), .int_prio(int_prio),
    .arb_en(arb_en), .cpu_int_ack(cpu_int_ack), .cpu_int_exit(cpu_int_exit),
    .arb_int_req(arb_int_req), .arb_int_vec(arb_int_vec), .arb_int_prio(arb_int_prio),
    .arb_pending_clr(arb_pending_clr), .arb_nest_lvl(arb_nest_lvl), .arb_exit_err(arb_exit_err)
  );

  always #5 wic_clk = ~wic_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic set_prio(input int src, input logic [1:0] p);
    int_prio[src*2 +: 2] = p;
  endtask

  // Queue the expectation for the state after the next edge, then clock and score it.
  task automatic cyc(input string tag, input logic req, input int vec, input logic [1:0] prio,
                     input bit cv, input logic [31:0] clr, input int lvl);
    exp_t e, g;
    e.tag = tag; e.req = req; e.vec = 5'(vec); e.prio = prio; e.cv = cv;
    e.clr = clr; e.lvl = 3'(lvl); e.err = err_exp;
    sb_q.push_back(e);
    @(posedge wic_clk);
    #1;
    g = sb_q.pop_front();
    chk({g.tag, ".req"}, 32'(arb_int_req), 32'(g.req));
    chk({g.tag, ".clr"}, arb_pending_clr, g.clr);
    chk({g.tag, ".lvl"}, 32'(arb_nest_lvl), 32'(g.lvl));
    chk({g.tag, ".err"}, 32'(arb_exit_err), 32'(g.err));
    if (g.cv) begin
      chk({g.tag, ".vec"},  32'(arb_int_vec),  32'(g.vec));
      chk({g.tag, ".prio"}, 32'(arb_int_prio), 32'(g.prio));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".req"},  32'(arb_int_req), 0);
    chk({tag, ".vec"},  32'(arb_int_vec), 0);
    chk({tag, ".prio"}, 32'(arb_int_prio), 0);
    chk({tag, ".clr"},  arb_pending_clr, 0);
    chk({tag, ".lvl"},  32'(arb_nest_lvl), 0);
    chk({tag, ".err"},  32'(arb_exit_err), 0);
  endtask

  initial begin
    pad_cpu_rst_b = 1'b0;
    int_pending = '0; int_enable = '1; int_prio = '0;
    arb_en = 1'b1; cpu_int_ack = 1'b0; cpu_int_exit = 1'b0;
    #12;
    chk_zero("rst");
    pad_cpu_rst_b = 1'b1;

    // single source
    set_prio(3, 1); int_pending[3] = 1'b1;
    cyc("t1_req", 1, 3, 1, 1, 0, 0);
    cpu_int_ack = 1'b1;
    cyc("t1_clr", 0, 3, 1, 1, 32'h8, 1);
    cpu_int_ack = 1'b0; int_pending[3] = 1'b0;
    cyc("t1_idle", 0, 0, 0, 0, 0, 1);
    cpu_int_exit = 1'b1;
    cyc("t1_exit", 0, 0, 0, 0, 0, 0);
    cpu_int_exit = 1'b0; cpu_int_ack = 1'b1;
    cyc("ack_idle", 0, 0, 0, 0, 0, 0);
    cpu_int_ack = 1'b0;

    // priority and tie
    set_prio(5, 2); set_prio(9, 2); set_prio(1, 1);
    int_pending = 32'h0000_0222;
    cyc("t2_req5", 1, 5, 2, 1, 0, 0);
    cpu_int_ack = 1'b1;
    cyc("t2_clr5", 0, 5, 2, 1, 32'h20, 1);
    cpu_int_ack = 1'b0; int_pending[5] = 1'b0;
    cyc("t2_blk9", 0, 0, 0, 0, 0, 1);
    cpu_int_exit = 1'b1;
    cyc("t2_exit", 0, 0, 0, 0, 0, 0);
    cpu_int_exit = 1'b0;
    cyc("t2_req9", 1, 9, 2, 1, 0, 0);
    cpu_int_ack = 1'b1;
    cyc("t2_clr9", 0, 9, 2, 1, 32'h200, 1);
    cpu_int_ack = 1'b0; int_pending[9] = 1'b0;
    cyc("t2_blk1", 0, 0, 0, 0, 0, 1);
    cpu_int_exit = 1'b1;
    cyc("t2_exit2", 0, 0, 0, 0, 0, 0);
    cpu_int_exit = 1'b0;
    cyc("t2_req1", 1, 1, 1, 1, 0, 0);
    int_pending = '0;
    cyc("t2_wdraw", 0, 0, 0, 0, 0, 0);

    // nesting
    set_prio(4, 1); int_pending[4] = 1'b1;
    cyc("t3_req4", 1, 4, 1, 1, 0, 0);
    cpu_int_ack = 1'b1;
    cyc("t3_clr4", 0, 4, 1, 1, 32'h10, 1);
    cpu_int_ack = 1'b0; int_pending = '0;
    set_prio(7, 1); int_pending[7] = 1'b1;
    cyc("t3_idle", 0, 0, 0, 0, 0, 1);
    cyc("t3_eqblk", 0, 0, 0, 0, 0, 1);
    set_prio(7, 3);
    cyc("t3_req7", 1, 7, 3, 1, 0, 1);
    cpu_int_ack = 1'b1;
    cyc("t3_clr7", 0, 7, 3, 1, 32'h80, 2);
    cpu_int_ack = 1'b0; int_pending = '0;
    cyc("t3_lvl2", 0, 0, 0, 0, 0, 2);
    cpu_int_exit = 1'b1;
    cyc("t3_ex1", 0, 0, 0, 0, 0, 1);
    cyc("t3_ex2", 0, 0, 0, 0, 0, 0);
    cpu_int_exit = 1'b0;

    // preemption before ack
    set_prio(2, 0); set_prio(10, 3); int_pending[2] = 1'b1;
    cyc("t4_req2", 1, 2, 0, 1, 0, 0);
    int_pending[10] = 1'b1;
    cyc("t4_pre10", 1, 10, 3, 1, 0, 0);
    cpu_int_ack = 1'b1;
    cyc("t4_clr10", 0, 10, 3, 1, 32'h400, 1);
    cpu_int_ack = 1'b0; int_pending[10] = 1'b0;
    cyc("t4_blk2", 0, 0, 0, 0, 0, 1);
    cpu_int_exit = 1'b1;
    cyc("t4_exit", 0, 0, 0, 0, 0, 0);
    cpu_int_exit = 1'b0;
    cyc("t4_req2b", 1, 2, 0, 1, 0, 0);
    int_pending = '0;
    cyc("t4_wdraw", 0, 0, 0, 0, 0, 0);

    // exit with empty stack
    cpu_int_exit = 1'b1; err_exp = 1'b1;
    cyc("t5_err", 0, 0, 0, 0, 0, 0);
    cpu_int_exit = 1'b0;
    cyc("t5_sticky", 0, 0, 0, 0, 0, 0);

    // four nested acks fill the stack
    for (int k = 0; k < 4; k++) begin
      set_prio(11 + k, 2'(k)); int_pending[11 + k] = 1'b1;
      cyc($sformatf("t6_req%0d", k), 1, 11 + k, 2'(k), 1, 0, k);
      cpu_int_ack = 1'b1;
      cyc($sformatf("t6_clr%0d", k), 0, 11 + k, 2'(k), 1, 32'h1 << (11 + k), k + 1);
      cpu_int_ack = 1'b0; int_pending[11 + k] = 1'b0;
      cyc($sformatf("t6_idle%0d", k), 0, 0, 0, 0, 0, k + 1);
    end
    set_prio(15, 3); int_pending[15] = 1'b1;
    cyc("t6_full0", 0, 0, 0, 0, 0, 4);
    cyc("t6_full1", 0, 0, 0, 0, 0, 4);
    int_pending = '0;

    // ack and exit together at level 2
    cpu_int_exit = 1'b1;
    cyc("t7_ex3", 0, 0, 0, 0, 0, 3);
    cyc("t7_ex2", 0, 0, 0, 0, 0, 2);
    cpu_int_exit = 1'b0;
    set_prio(16, 2); int_pending[16] = 1'b1;
    cyc("t7_req16", 1, 16, 2, 1, 0, 2);
    cpu_int_ack = 1'b1; cpu_int_exit = 1'b1;
    cyc("t7_clr16", 0, 16, 2, 1, 32'h1_0000, 2);
    cpu_int_ack = 1'b0; cpu_int_exit = 1'b0; int_pending = '0;
    set_prio(17, 2); int_pending[17] = 1'b1;
    cyc("t7_idle", 0, 0, 0, 0, 0, 2);
    cyc("t7_topblk", 0, 0, 0, 0, 0, 2);
    int_pending = '0; cpu_int_exit = 1'b1;
    cyc("t7_ex1", 0, 0, 0, 0, 0, 1);
    cyc("t7_ex0", 0, 0, 0, 0, 0, 0);
    cpu_int_exit = 1'b0;

    // arb_en drop in REQ, and ack winning over arb_en drop
    set_prio(20, 1); int_pending[20] = 1'b1;
    cyc("t8_req", 1, 20, 1, 1, 0, 0);
    arb_en = 1'b0;
    cyc("t8_drop", 0, 0, 0, 0, 0, 0);
    arb_en = 1'b1;
    cyc("t8_req2", 1, 20, 1, 1, 0, 0);
    arb_en = 1'b0; cpu_int_ack = 1'b1;
    cyc("t8_ackwin", 0, 20, 1, 1, 32'h10_0000, 1);
    arb_en = 1'b1; cpu_int_ack = 1'b0; int_pending = '0;
    cyc("t8_idle", 0, 0, 0, 0, 0, 1);
    cpu_int_exit = 1'b1;
    cyc("t8_exit", 0, 0, 0, 0, 0, 0);
    cpu_int_exit = 1'b0;

    // reset during CLR
    set_prio(21, 1); int_pending[21] = 1'b1;
    cyc("t9_req", 1, 21, 1, 1, 0, 0);
    cpu_int_ack = 1'b1;
    cyc("t9_clr", 0, 21, 1, 1, 32'h20_0000, 1);
    pad_cpu_rst_b = 1'b0;
    #1;
    chk_zero("t9_async");
    cpu_int_ack = 1'b0; int_pending = '0; err_exp = 1'b0;
    cyc("t9_inrst", 0, 0, 0, 1, 0, 0);
    pad_cpu_rst_b = 1'b1;
    cyc("t9_post", 0, 0, 0, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
